// File: rtl/ajit_acc_pkg.sv
// Shared definitions for the AJIT accelerator memory mover: ACB request and
// response field layout, fixed request constants, FSM state type and the
// request packing helper.
package ajit_acc_pkg;

  localparam int unsigned ACB_REQ_W    = 110;
  localparam int unsigned ACB_RESP_W   = 65;
  localparam int unsigned ACB_ADDR_W   = 36;
  localparam int unsigned ACB_DATA_W   = 64;

  localparam int unsigned REQ_LOCK_BIT = 109;
  localparam int unsigned REQ_READ_BIT = 108;
  localparam int unsigned REQ_MASK_LSB = 100;
  localparam int unsigned REQ_MASK_W   = 8;
  localparam int unsigned REQ_ADDR_LSB = 64;
  localparam int unsigned RESP_ERR_BIT = 64;

  localparam logic                  REQ_LOCK = 1'b0;
  localparam logic [REQ_MASK_W-1:0] REQ_MASK = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_WAIT_RESP,
    ST_STREAM_OUT,
    ST_DONE
  } mover_state_e;

  // Full-doubleword, unlocked request; the data field is forced to zero on reads.
  function automatic logic [ACB_REQ_W-1:0] acb_pack_req(
    input logic                  is_read,
    input logic [ACB_ADDR_W-1:0] addr,
    input logic [ACB_DATA_W-1:0] data
  );
    logic [ACB_REQ_W-1:0] req;
    req                                = '0;
    req[REQ_LOCK_BIT]                  = REQ_LOCK;
    req[REQ_READ_BIT]                  = is_read;
    req[REQ_MASK_LSB +: REQ_MASK_W]    = REQ_MASK;
    req[REQ_ADDR_LSB +: ACB_ADDR_W]    = addr;
    req[ACB_DATA_W-1:0]                = is_read ? '0 : data;
    return req;
  endfunction

endpackage

// File: rtl/ajit_acc_acb_mover.sv
// AJIT accelerator memory-side mover: moves a run of 64-bit doublewords
// between system memory (ACB request/response pipes) and the datapath
// streams, one request outstanding at a time.
module ajit_acc_acb_mover
  import ajit_acc_pkg::*;
#(
  parameter int unsigned ADDR_W = 36,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_start,
  input  logic                  cmd_is_read,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [CNT_W-1:0]      cmd_count,
  output logic                  cmd_busy,
  output logic                  cmd_done,
  output logic                  cmd_error,
  output logic [63:0]           rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  input  logic [63:0]           wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [ACB_REQ_W-1:0]  ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data,
  input  logic                  ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req,
  output logic                  ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack,
  input  logic [ACB_RESP_W-1:0] ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data,
  input  logic                  ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req,
  output logic                  ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack
);

  mover_state_e         state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 is_read_q, is_read_d;
  logic                 error_q, error_d;
  logic [63:0]          rd_data_q, rd_data_d;
  logic [ACB_REQ_W-1:0] req_data_q, req_data_d;

  logic [ADDR_W-1:0]    start_addr;
  logic                 req_fire;
  logic                 resp_fire;
  logic                 resp_err;

  assign start_addr = {cmd_addr[ADDR_W-1:3], 3'b000};
  assign req_fire   = (state_q == ST_ISSUE) && ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req;
  assign resp_fire  = (state_q == ST_WAIT_RESP) && ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req;
  assign resp_err   = ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data[RESP_ERR_BIT];

  // State and datapath registers; reset returns to IDLE with all outputs cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      count_q    <= '0;
      is_read_q  <= 1'b0;
      error_q    <= 1'b0;
      rd_data_q  <= '0;
      req_data_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      is_read_q  <= is_read_d;
      error_q    <= error_d;
      rd_data_q  <= rd_data_d;
      req_data_q <= req_data_d;
    end
  end

  // Next-state and register update logic.
  // Read requests are packed one cycle early (on start and on stream handshake)
  // so the request word is already registered when ISSUE presents it.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    count_d    = count_q;
    is_read_d  = is_read_q;
    error_d    = error_q;
    rd_data_d  = rd_data_q;
    req_data_d = req_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_start) begin
          addr_d    = start_addr;
          count_d   = cmd_count;
          is_read_d = cmd_is_read;
          error_d   = 1'b0;
          if (cmd_count == '0) begin
            state_d = ST_DONE;
          end else if (cmd_is_read) begin
            req_data_d = acb_pack_req(1'b1, ACB_ADDR_W'(start_addr), '0);
            state_d    = ST_ISSUE;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        if (wr_valid) begin
          req_data_d = acb_pack_req(1'b0, ACB_ADDR_W'(addr_q), wr_data);
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (req_fire) state_d = ST_WAIT_RESP;
      end
      ST_WAIT_RESP: begin
        if (resp_fire) begin
          if (resp_err) begin
            error_d = 1'b1;
            state_d = ST_DONE;
          end else begin
            addr_d  = addr_q + ADDR_W'(8);
            count_d = count_q - CNT_W'(1);
            if (is_read_q) begin
              rd_data_d = ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data[ACB_DATA_W-1:0];
              state_d   = ST_STREAM_OUT;
            end else begin
              state_d = (count_q == CNT_W'(1)) ? ST_DONE : ST_FETCH;
            end
          end
        end
      end
      ST_STREAM_OUT: begin
        if (rd_ready) begin
          if (count_q == '0) begin
            state_d = ST_DONE;
          end else begin
            req_data_d = acb_pack_req(1'b1, ACB_ADDR_W'(addr_q), '0);
            state_d    = ST_ISSUE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign cmd_busy  = (state_q != ST_IDLE);
  assign cmd_done  = (state_q == ST_DONE);
  assign cmd_error = error_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = (state_q == ST_STREAM_OUT);
  assign wr_ready  = (state_q == ST_FETCH);

  assign ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data  = req_data_q;
  assign ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack   = (state_q == ST_ISSUE);
  assign ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack = (state_q == ST_WAIT_RESP);

endmodule

// File: tb/tb_ajit_acc_acb_mover.sv
// Scoreboard bench for ajit_acc_acb_mover: commands are expanded by a
// behavioural model into expected ACB requests, read beats and completion
// status; a negedge monitor pops and compares as the DUT presents them.
module tb_ajit_acc_acb_mover;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         cmd_start = 1'b0;
  logic         cmd_is_read = 1'b0;
  logic [35:0]  cmd_addr = '0;
  logic [15:0]  cmd_count = '0;
  logic         cmd_busy, cmd_done, cmd_error;
  logic [63:0]  rd_data;
  logic         rd_valid;
  logic         rd_ready = 1'b0;
  logic [63:0]  wr_data = '0;
  logic         wr_valid = 1'b0;
  logic         wr_ready;
  logic [109:0] req_data;
  logic         req_req = 1'b0;
  logic         req_ack;
  logic [64:0]  resp_data = '0;
  logic         resp_req;
  logic         resp_ack;
  logic         resp_drv = 1'b0;
  logic         junk_resp = 1'b0;

  assign resp_req = resp_drv | junk_resp;

  ajit_acc_acb_mover #(.ADDR_W(36), .CNT_W(16)) dut (
    .clk                                          (clk),
    .reset                                        (reset),
    .cmd_start                                    (cmd_start),
    .cmd_is_read                                  (cmd_is_read),
    .cmd_addr                                     (cmd_addr),
    .cmd_count                                    (cmd_count),
    .cmd_busy                                     (cmd_busy),
    .cmd_done                                     (cmd_done),
    .cmd_error                                    (cmd_error),
    .rd_data                                      (rd_data),
    .rd_valid                                     (rd_valid),
    .rd_ready                                     (rd_ready),
    .wr_data                                      (wr_data),
    .wr_valid                                     (wr_valid),
    .wr_ready                                     (wr_ready),
    .ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data   (req_data),
    .ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req    (req_req),
    .ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack    (req_ack),
    .ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data (resp_data),
    .ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req  (resp_req),
    .ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack  (resp_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic [35:0] addr;
    logic        err;
  } pend_t;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int err_at = -1;
  int req_idx = 0;
  bit quiet_resp = 1'b0;
  bit bp_req = 1'b0;
  bit bp_rd = 1'b0;
  bit wr_taken = 1'b0;
  bit resp_taken = 1'b0;

  logic [109:0] exp_req_q[$];
  logic [63:0]  exp_rd_q[$];
  logic         exp_err_q[$];
  logic [63:0]  wr_words_q[$];
  pend_t        pend_q[$];

  // Memory contents are a fixed function of the doubleword address.
  function automatic logic [63:0] mem_word(input logic [35:0] a);
    return {a[31:0] ^ 32'hA5A5_5A5A, ~a[35:4]};
  endfunction

  function automatic logic [109:0] mk_req(input logic rd, input logic [35:0] a, input logic [63:0] d);
    return {1'b0, rd, 8'hFF, a, (rd ? 64'h0 : d)};
  endfunction

  task automatic check(input string name, input logic [109:0] act, input logic [109:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Environment drivers: random ready/valid, memory responder.
  initial begin
    pend_t p;
    forever begin
      @(posedge clk); #1;
      req_req  = !bp_req && ($urandom_range(0, 3) != 0);
      rd_ready = !bp_rd && ($urandom_range(0, 3) != 0);
      if (wr_taken) begin
        wr_words_q.delete(0);
        wr_valid = 1'b0;
        wr_taken = 1'b0;
      end
      if (!wr_valid && wr_words_q.size() > 0 && $urandom_range(0, 2) != 0) begin
        wr_valid = 1'b1;
        wr_data  = wr_words_q[0];
      end
      if (resp_taken) begin
        pend_q.delete(0);
        resp_drv   = 1'b0;
        resp_taken = 1'b0;
      end
      if (!resp_drv && !quiet_resp && pend_q.size() > 0 && $urandom_range(0, 2) != 0) begin
        p         = pend_q[0];
        resp_drv  = 1'b1;
        resp_data = {p.err, (p.rd ? mem_word(p.addr) : {$urandom, $urandom})};
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    bit           req_wait = 1'b0;
    bit           rd_wait = 1'b0;
    logic [109:0] prev_req = '0;
    logic [63:0]  prev_rd = '0;
    pend_t        p;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (req_wait) begin
          chk("req_ack_held", int'(req_ack), 1);
          check("req_data_held", req_data, prev_req);
        end
        if (rd_wait) begin
          chk("rd_valid_held", int'(rd_valid), 1);
          check("rd_data_held", 110'(rd_data), 110'(prev_rd));
        end
        if (req_ack) chk("req_ack_expected", int'(exp_req_q.size() != 0), 1);
        if (req_ack && req_req) begin
          if (exp_req_q.size() == 0) begin
            chk("req_unexpected", 1, 0);
          end else begin
            check("req_data", req_data, exp_req_q.pop_front());
          end
          p.rd   = req_data[108];
          p.addr = req_data[99:64];
          p.err  = (req_idx == err_at);
          pend_q.push_back(p);
          req_idx++;
        end
        if (rd_valid && rd_ready) begin
          if (exp_rd_q.size() == 0) chk("rd_unexpected", 1, 0);
          else check("rd_data", 110'(rd_data), 110'(exp_rd_q.pop_front()));
        end
        if (wr_valid && wr_ready) wr_taken = 1'b1;
        if (resp_req && resp_ack) resp_taken = 1'b1;
        if (cmd_done) begin
          done_cnt++;
          chk("busy_in_done", int'(cmd_busy), 1);
          if (exp_err_q.size() == 0) chk("done_unexpected", 1, 0);
          else chk("done_error", int'(cmd_error), int'(exp_err_q.pop_front()));
        end
        req_wait = req_ack && !req_req;
        rd_wait  = rd_valid && !rd_ready;
        prev_req = req_data;
        prev_rd  = rd_data;
      end else begin
        req_wait = 1'b0;
        rd_wait  = 1'b0;
      end
    end
  end

  // Model a command, issue it, and wait for its completion.
  task automatic run_cmd(input logic rd, input logic [35:0] addr, input int cnt,
                         input int err_i, input bit bp);
    logic [35:0] base, a;
    logic [63:0] w;
    logic        exp_err;
    int          n, d0, k;
    base    = {addr[35:3], 3'b000};
    exp_err = (err_i >= 0 && err_i < cnt);
    n       = exp_err ? err_i + 1 : cnt;
    for (int i = 0; i < n; i++) begin
      a = base + 36'(8 * i);
      if (rd) begin
        exp_req_q.push_back(mk_req(1'b1, a, 64'h0));
        if (i != err_i) exp_rd_q.push_back(mem_word(a));
      end else begin
        w = {$urandom, $urandom};
        wr_words_q.push_back(w);
        exp_req_q.push_back(mk_req(1'b0, a, w));
      end
    end
    exp_err_q.push_back(exp_err);
    err_at  = err_i;
    req_idx = 0;
    d0      = done_cnt;
    if (bp) begin
      @(negedge clk);
      bp_req = 1'b1;
      bp_rd  = 1'b1;
    end
    @(posedge clk); #2;
    cmd_is_read = rd;
    cmd_addr    = addr;
    cmd_count   = 16'(cnt);
    cmd_start   = 1'b1;
    @(posedge clk); #2;
    chk("busy_rise", int'(cmd_busy), 1);
    cmd_is_read = $urandom_range(0, 1) != 0;
    cmd_addr    = {4'($urandom), $urandom};
    cmd_count   = 16'($urandom);
    @(posedge clk); #2;
    cmd_start = 1'b0;
    if (bp) begin
      repeat (5) @(negedge clk);
      bp_req = 1'b0;
      k = 0;
      while (!rd_valid && k < 200) begin
        @(negedge clk);
        k++;
      end
      repeat (4) @(negedge clk);
      bp_rd = 1'b0;
    end
    k = 0;
    while (done_cnt == d0 && k < 3000) begin
      @(negedge clk); #1;
      k++;
    end
    if (done_cnt == d0) chk("done_timeout", 0, 1);
    @(posedge clk); #2;
    chk("busy_fall", int'(cmd_busy), 0);
    chk("error_sticky", int'(cmd_error), int'(exp_err));
    chk("req_drained", exp_req_q.size(), 0);
    chk("rd_drained", exp_rd_q.size(), 0);
    chk("wr_drained", wr_words_q.size(), 0);
    exp_req_q.delete();
    exp_rd_q.delete();
    wr_words_q.delete();
    err_at = -1;
  endtask

  initial begin
    int k, d0;
    int cnt, ei;
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, d0, cnt, ei;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(cmd_busy), 0);
    chk("rst_done", int'(cmd_done), 0);
    chk("rst_error", int'(cmd_error), 0);
    chk("rst_req_ack", int'(req_ack), 0);
    check("rst_req_data", req_data, 110'h0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    run_cmd(1'b1, 36'h0_0000_1000, 3, -1, 1'b0);
    run_cmd(1'b0, 36'h0_0000_2000, 2, -1, 1'b0);
    run_cmd(1'b1, 36'h0_0000_4000, 0, -1, 1'b0);
    run_cmd(1'b0, 36'h0_0000_4100, 0, -1, 1'b0);
    run_cmd(1'b1, 36'h0_0000_5000, 4, 1, 1'b0);
    run_cmd(1'b1, 36'h0_0000_6005, 2, -1, 1'b1);
    run_cmd(1'b1, 36'hF_FFFF_FFF8, 2, -1, 1'b0);
    run_cmd(1'b0, 36'hF_FFFF_FFFB, 2, -1, 1'b0);
    run_cmd(1'b0, 36'h0_0000_7000, 3, 2, 1'b0);

    for (int i = 0; i < 16; i++) begin
      cnt = $urandom_range(0, 5);
      ei  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : -1;
      run_cmd($urandom_range(0, 1) != 0, {4'($urandom), $urandom}, cnt, ei, 1'b0);
    end

    // Error stays sticky in idle; reset clears it.
    run_cmd(1'b1, 36'h0_0000_8000, 2, 0, 1'b0);
    repeat (3) @(negedge clk);
    chk("error_idle_sticky", int'(cmd_error), 1);
    reset = 1'b0;
    #1;
    chk("error_reset", int'(cmd_error), 0);
    @(negedge clk);
    reset = 1'b1;

    // A response presented outside WAIT_RESP is never acknowledged.
    @(negedge clk);
    junk_resp = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("resp_ack_idle", int'(resp_ack), 0);
    end
    junk_resp = 1'b0;

    // Reset asserted while waiting for a response.
    run_cmd(1'b1, 36'h0_0000_9000, 1, -1, 1'b0);
    quiet_resp = 1'b1;
    exp_req_q.push_back(mk_req(1'b1, 36'h0_0000_A000, 64'h0));
    @(posedge clk); #2;
    cmd_is_read = 1'b1;
    cmd_addr    = 36'h0_0000_A000;
    cmd_count   = 16'd3;
    cmd_start   = 1'b1;
    @(posedge clk); #2;
    cmd_start = 1'b0;
    k = 0;
    while (!resp_ack && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("reached_wait_resp", int'(resp_ack), 1);
    d0 = done_cnt;
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", int'(cmd_busy), 0);
    chk("mid_rst_resp_ack", int'(resp_ack), 0);
    chk("mid_rst_req_ack", int'(req_ack), 0);
    chk("mid_rst_rd_valid", int'(rd_valid), 0);
    chk("mid_rst_wr_ready", int'(wr_ready), 0);
    check("mid_rst_rd_data", 110'(rd_data), 110'h0);
    check("mid_rst_req_data", req_data, 110'h0);
    exp_req_q.delete();
    exp_rd_q.delete();
    exp_err_q.delete();
    pend_q.delete();
    wr_words_q.delete();
    resp_drv   = 1'b0;
    resp_taken = 1'b0;
    wr_taken   = 1'b0;
    wr_valid   = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_rst_no_done", done_cnt, d0);
    reset      = 1'b1;
    quiet_resp = 1'b0;
    run_cmd(1'b0, 36'h0_0000_B000, 2, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
